bo_arbiter: RTL and testbench
=============================

// Module: bo_arbiter
// PURPOSE
// - Shares one operative block (datapath plus its JK-style control block) between N_REQ requesters.
// - Round-robin arbitration; loads the winner's operand and pulses the datapath start (w).
// - Waits for datapath done, captures the result and returns it with a one-cycle ack.
// - Sits between the requesting units and the datapath/control-block pair. Owns the control block's clear.
// PARAMETERS
// - N_REQ    2   number of requesters, 2..4
// - DATA_W   8   operand/result width
// - TIMEOUT  64  max RUN cycles before abort (used only with BO_ARB_TIMEOUT_EN)
// PORTS
// - clk       in   1               system clock, rising edge
// - rst       in   1               asynchronous reset, active-low
// - req       in   N_REQ           request per requester; level, held until its ack
// - op_i      in   N_REQ*DATA_W    operands; requester k uses slice [k*DATA_W +: DATA_W]
// - gnt       out  N_REQ           one-hot grant, registered
// - ack       out  N_REQ           one-hot, one-cycle completion pulse
// - res_o     out  DATA_W          result; valid while ack is high, held until the next capture
// - busy      out  1               high in any state other than IDLE
// - err       out  1               one-cycle abort flag, coincident with ack
// - dp_x      out  DATA_W          operand to the datapath, registered, held during the operation
// - dp_start  out  1               start strobe to the control block (its w input)
// - dp_done   in   1               done from the control block
// - dp_res    in   DATA_W          datapath result
// - dp_clr    out  1               active-high reset to the control block
// BEHAVIOUR
// - Moore FSM, one-hot or binary at implementer's choice. States: CLR, IDLE, LOAD, RUN, ACK.
//   - All outputs are decoded from registers; there is no combinational path from inputs to outputs.
// - Reset (rst=0, asynchronous):
//   - state=CLR, ptr=0, gnt=0, ack=0, res_o=0, dp_x=0, err=0, dp_start=0, busy=1.
//   - dp_clr=1 while rst=0 and for the whole CLR cycle.
//   - Reset mid-operation abandons the operation with no ack.
// - CLR -> IDLE unconditionally.
// - IDLE, any req=1: winner = first k with req[k]=1, searching ptr, ptr+1, ... and wrapping modulo N_REQ.
//   - On the same edge: gnt[winner]<=1, dp_x<=op slice of winner, go to LOAD.
// - IDLE, req=0: stay in IDLE, all strobes low.
// - LOAD: dp_start=1 for exactly this one cycle, then go to RUN.
// - RUN: dp_start=0.
//   - dp_done=1 on a clock edge: res_o<=dp_res, go to ACK.
//   - dp_done may already be 1 in the first RUN cycle.
// - ACK: ack[winner]=1 for this one cycle, gnt still held.
//   - Next edge: gnt<=0, ptr<=(winner+1) mod N_REQ, go to IDLE.
// - Grant covers the LOAD, RUN and ACK states. Minimum request-to-ack latency: 3 edges. Minimum turnaround: 4 cycles.
// - Handshake rules:
//   - req dropped during LOAD/RUN: the operation still completes and ack still pulses.
//   - req still high after ack: the requester is re-arbitrated as a new request. ptr guarantees fairness.
//   - dp_done is ignored in CLR, IDLE, LOAD and ACK.
//   - req and ack high for the same requester in one cycle is legal.
// - ptr arithmetic wraps: N_REQ-1 -> 0.
// - Requesters k >= N_REQ do not exist, so no masking is needed.
// CONFIGURATION
// - BO_ARB_TIMEOUT_EN defined:
//   - A cycle counter is cleared on entry to RUN and increments each RUN cycle.
//   - If it reaches TIMEOUT-1 with dp_done=0: res_o<=0, go to ACK with err=1.
//   - ACK then goes to CLR instead of IDLE, so dp_clr pulses for one cycle. ptr still advances.
//   - dp_done on that same edge wins: normal completion, err=0.
// - BO_ARB_TIMEOUT_EN undefined: there is no counter, RUN waits indefinitely, and err is tied to 0.
// TESTING
// - Reset release: dp_clr=1 during reset and the CLR cycle, then 0; busy=0 from the 2nd cycle; all other outputs 0.
// - Single request: N_REQ=2, req=01, op_i[7:0]=8'h2A, dp_done 3 cycles after dp_start, dp_res=8'h15
//   -> gnt=01, dp_x=8'h2A, one dp_start pulse, ack=01 with res_o=8'h15, then IDLE.
// - Contention: req=11 held continuously -> grants alternate 01,10,01,10 starting with 01. Each grant gets exactly one ack.
// - Early done and early drop:
//   - dp_done=1 in the first RUN cycle -> ack 3 edges after req.
//   - req dropped during RUN -> ack still pulses.
//   - Stray dp_done in IDLE -> no effect.
// - Reset mid-RUN: rst=0 while dp_start has occurred and no done -> no ack; gnt=0, ptr=0 and dp_clr=1 immediately (asynchronous).
// - BO_ARB_TIMEOUT_EN, TIMEOUT=8, dp_done held 0:
//   - ack and err pulse together, then one dp_clr cycle, then the next requester is served.
//   - Without the macro, the block stays in RUN and err remains 0.

Source files
------------

// File: rtl/bo_arbiter.sv
// ---------------------------------------------------------------------------
// bo_arbiter
//
// Purpose: lets N_REQ requesters share one datapath and its JK-style control
// block. A round-robin arbiter picks a requester, loads its operand into the
// datapath, pulses the control block's start (w) input and waits for done.
// It then captures the result and returns it with a one-cycle ack. The
// arbiter also owns the control block's clear.
//
// Optional feature macro: BO_ARB_TIMEOUT_EN
//   defined   - RUN is aborted after TIMEOUT cycles without done. The abort
//               returns res_o=0 with err=1 on the ack cycle, then passes
//               through CLR so the control block is cleared again.
//   undefined - RUN waits indefinitely and err is tied to 0.
//
// Ports:
//   clk       in   1             system clock, rising edge
//   rst       in   1             asynchronous reset, active-low
//   req       in   N_REQ         level request per requester, held until ack
//   op_i      in   N_REQ*DATA_W  operands, requester k at [k*DATA_W +: DATA_W]
//   gnt       out  N_REQ         one-hot grant (LOAD, RUN, ACK)
//   ack       out  N_REQ         one-hot, one-cycle completion pulse
//   res_o     out  DATA_W        result, held until the next capture
//   busy      out  1             high in every state except IDLE
//   err       out  1             abort flag, coincident with ack
//   dp_x      out  DATA_W        operand to the datapath
//   dp_start  out  1             start strobe (w) to the control block
//   dp_done   in   1             done from the control block
//   dp_res    in   DATA_W        datapath result
//   dp_clr    out  1             active-high clear to the control block
// ---------------------------------------------------------------------------
module bo_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   op_i,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         res_o,
    output logic                      busy,
    output logic                      err,
    output logic [DATA_W-1:0]         dp_x,
    output logic                      dp_start,
    input  logic                      dp_done,
    input  logic [DATA_W-1:0]         dp_res,
    output logic                      dp_clr
);

    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

    // Catch parameter sets the arbiter was not built for at elaboration time.
    if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 2) begin : g_param_check
        $error("bo_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        ST_CLR  = 3'd0,
        ST_IDLE = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   dp_x_q, dp_x_d;
    logic                pick_found_s;
    logic [PTR_W-1:0]    pick_idx_s;

`ifdef BO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Round-robin search: first requester at or after ptr, wrapping mod N_REQ.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found_s && req[(int'(ptr_q) + i) % N_REQ]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = PTR_W'((int'(ptr_q) + i) % N_REQ);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state and register-update logic for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        res_d   = res_q;
        dp_x_d  = dp_x_q;
`ifdef BO_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_CLR: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (pick_found_s) begin
                    win_d             = pick_idx_s;
                    gnt_d             = '0;
                    gnt_d[pick_idx_s] = 1'b1;
                    dp_x_d            = op_i[int'(pick_idx_s)*DATA_W +: DATA_W];
                    state_d           = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
`ifdef BO_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // done on the same edge as the timeout still counts as success
                if (dp_done) begin
                    res_d   = dp_res;
`ifdef BO_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_ACK;
                end else begin
`ifdef BO_ARB_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_ACK: begin
                gnt_d = '0;
                if (win_q == PTR_W'(N_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win_q + PTR_W'(1);
                end
`ifdef BO_ARB_TIMEOUT_EN
                err_d = 1'b0;
                // an aborted operation leaves the control block in an unknown
                // state, so clear it before serving anyone else
                if (err_q) begin
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_CLR;
            end
        endcase
    end

    // State and datapath-side registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLR;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            res_q   <= '0;
            dp_x_q  <= '0;
`ifdef BO_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            res_q   <= res_d;
            dp_x_q  <= dp_x_d;
`ifdef BO_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Moore outputs, decoded only from registers.
    assign gnt      = gnt_q;
    assign ack      = (state_q == ST_ACK) ? gnt_q : {N_REQ{1'b0}};
    assign res_o    = res_q;
    assign busy     = (state_q != ST_IDLE);
    assign dp_x     = dp_x_q;
    assign dp_start = (state_q == ST_LOAD);
    assign dp_clr   = (state_q == ST_CLR);
`ifdef BO_ARB_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_bo_arbiter.sv
module tb_bo_arbiter;

    localparam int N_REQ   = 2;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 8;

    logic                     clk;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*DATA_W-1:0]  op_i;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         ack;
    logic [DATA_W-1:0]        res_o;
    logic                     busy;
    logic                     err;
    logic [DATA_W-1:0]        dp_x;
    logic                     dp_start;
    logic                     dp_done;
    logic [DATA_W-1:0]        dp_res;
    logic                     dp_clr;

    int n_vec;
    int n_bad;

    bo_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op_i     (op_i),
        .gnt      (gnt),
        .ack      (ack),
        .res_o    (res_o),
        .busy     (busy),
        .err      (err),
        .dp_x     (dp_x),
        .dp_start (dp_start),
        .dp_done  (dp_done),
        .dp_res   (dp_res),
        .dp_clr   (dp_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] op;
        logic        done;
        logic [7:0]  dres;
        logic [1:0]  gnt;
        logic [1:0]  ack;
        logic [7:0]  res;
        logic        busy;
        logic        start;
        logic [7:0]  dpx;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input logic [1:0] r, input logic [15:0] op,
                                input logic d, input logic [7:0] dr,
                                input logic [1:0] g, input logic [1:0] a,
                                input logic [7:0] rs, input logic b,
                                input logic s, input logic [7:0] x);
        vec_t v;
        v.req = r; v.op = op; v.done = d; v.dres = dr;
        v.gnt = g; v.ack = a; v.res = rs; v.busy = b; v.start = s; v.dpx = x;
        return v;
    endfunction

    task automatic cyc(input logic [1:0] r, input logic [15:0] op,
                       input logic d, input logic [7:0] dr);
        req = r; op_i = op; dp_done = d; dp_res = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        logic got_ack;
        logic err_seen;
        logic busy_low;

        n_vec = 0;
        n_bad = 0;
        rst = 1'b0; req = '0; op_i = '0; dp_done = 1'b0; dp_res = '0;

        // single request, stray done, done ignored in LOAD, early done/drop
        tbl[0]  = mk(2'b01, 16'hB22A, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b1, 8'h2A);
        tbl[1]  = mk(2'b01, 16'hB22A, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 8'h2A);
        tbl[2]  = mk(2'b01, 16'hB22A, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 8'h2A);
        tbl[3]  = mk(2'b01, 16'hB22A, 1'b0, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 8'h2A);
        tbl[4]  = mk(2'b01, 16'hB22A, 1'b1, 8'h15, 2'b01, 2'b01, 8'h15, 1'b1, 1'b0, 8'h2A);
        tbl[5]  = mk(2'b00, 16'hB22A, 1'b0, 8'h00, 2'b00, 2'b00, 8'h15, 1'b0, 1'b0, 8'h2A);
        tbl[6]  = mk(2'b00, 16'hB22A, 1'b1, 8'hFF, 2'b00, 2'b00, 8'h15, 1'b0, 1'b0, 8'h2A);
        tbl[7]  = mk(2'b10, 16'hB22A, 1'b0, 8'h00, 2'b10, 2'b00, 8'h15, 1'b1, 1'b1, 8'hB2);
        tbl[8]  = mk(2'b10, 16'hB22A, 1'b1, 8'h33, 2'b10, 2'b00, 8'h15, 1'b1, 1'b0, 8'hB2);
        tbl[9]  = mk(2'b00, 16'hB22A, 1'b1, 8'h33, 2'b10, 2'b10, 8'h33, 1'b1, 1'b0, 8'hB2);
        tbl[10] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h33, 1'b0, 1'b0, 8'hB2);
        // contention: req=11 held, grants alternate 01,10,01,10
        tbl[11] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b01, 2'b00, 8'h33, 1'b1, 1'b1, 8'hA1);
        tbl[12] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b01, 2'b00, 8'h33, 1'b1, 1'b0, 8'hA1);
        tbl[13] = mk(2'b11, 16'hB2A1, 1'b1, 8'h44, 2'b01, 2'b01, 8'h44, 1'b1, 1'b0, 8'hA1);
        tbl[14] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h44, 1'b0, 1'b0, 8'hA1);
        tbl[15] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b10, 2'b00, 8'h44, 1'b1, 1'b1, 8'hB2);
        tbl[16] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b10, 2'b00, 8'h44, 1'b1, 1'b0, 8'hB2);
        tbl[17] = mk(2'b11, 16'hB2A1, 1'b1, 8'h55, 2'b10, 2'b10, 8'h55, 1'b1, 1'b0, 8'hB2);
        tbl[18] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h55, 1'b0, 1'b0, 8'hB2);
        tbl[19] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b01, 2'b00, 8'h55, 1'b1, 1'b1, 8'hA1);
        tbl[20] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b01, 2'b00, 8'h55, 1'b1, 1'b0, 8'hA1);
        tbl[21] = mk(2'b11, 16'hB2A1, 1'b1, 8'h66, 2'b01, 2'b01, 8'h66, 1'b1, 1'b0, 8'hA1);
        tbl[22] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h66, 1'b0, 1'b0, 8'hA1);
        tbl[23] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b10, 2'b00, 8'h66, 1'b1, 1'b1, 8'hB2);
        tbl[24] = mk(2'b11, 16'hB2A1, 1'b0, 8'h00, 2'b10, 2'b00, 8'h66, 1'b1, 1'b0, 8'hB2);
        tbl[25] = mk(2'b11, 16'hB2A1, 1'b1, 8'h77, 2'b10, 2'b10, 8'h77, 1'b1, 1'b0, 8'hB2);
        tbl[26] = mk(2'b00, 16'hB2A1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h77, 1'b0, 1'b0, 8'hB2);

        // ---- reset state ----
        #12;
        chk("reset_clr",   {31'd0, dp_clr}, 32'd1);
        chk("reset_busy",  {31'd0, busy},   32'd1);
        chk("reset_outs",  {gnt, ack, res_o, dp_x, dp_start, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("clr_cycle",   {30'd0, dp_clr, busy}, 32'd3);
        cyc(2'b00, 16'h0000, 1'b0, 8'h00);
        chk("idle_after_clr", {gnt, ack, res_o, dp_x, dp_start, err, dp_clr, busy}, 32'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 27; i++) begin
            cyc(tbl[i].req, tbl[i].op, tbl[i].done, tbl[i].dres);
            n_vec++;
            if (gnt !== tbl[i].gnt || ack !== tbl[i].ack || res_o !== tbl[i].res ||
                busy !== tbl[i].busy || dp_start !== tbl[i].start || dp_x !== tbl[i].dpx ||
                dp_clr !== 1'b0 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL row %0d: got gnt=%b ack=%b res=%h busy=%b start=%b dpx=%h clr=%b err=%b want gnt=%b ack=%b res=%h busy=%b start=%b dpx=%h clr=0 err=0",
                         i, gnt, ack, res_o, busy, dp_start, dp_x, dp_clr, err,
                         tbl[i].gnt, tbl[i].ack, tbl[i].res, tbl[i].busy, tbl[i].start, tbl[i].dpx);
            end
        end

        // ---- reset mid-RUN: serve requester 0 first so ptr moves to 1 ----
        cyc(2'b01, 16'hB2A1, 1'b0, 8'h00);
        cyc(2'b01, 16'hB2A1, 1'b0, 8'h00);
        cyc(2'b00, 16'hB2A1, 1'b1, 8'h88);
        chk("pre_rst_ack", {30'd0, ack}, 32'd1);
        cyc(2'b00, 16'hB2A1, 1'b0, 8'h00);
        cyc(2'b01, 16'hB2A1, 1'b0, 8'h00);
        cyc(2'b01, 16'hB2A1, 1'b0, 8'h00);
        cyc(2'b01, 16'hB2A1, 1'b0, 8'h00);
        chk("in_run", {28'd0, gnt, busy, dp_start}, 32'h6);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_clr", {31'd0, dp_clr}, 32'd1);
        chk("rst_async_outs", {gnt, ack, res_o, dp_x, dp_start, err}, 32'd0);
        @(posedge clk); #1;
        dp_done = 1'b1; dp_res = 8'hEE;
        @(posedge clk); #1;
        chk("rst_no_ack", {28'd0, ack, gnt}, 32'd0);
        rst = 1'b1;
        cyc(2'b11, 16'hB2A1, 1'b0, 8'h00);
        chk("rst_to_idle", {29'd0, dp_clr, busy, gnt[0]}, 32'd0);
        cyc(2'b11, 16'hB2A1, 1'b0, 8'h00);
        chk("ptr_reset_gnt", {30'd0, gnt}, 32'd1);
        cyc(2'b11, 16'hB2A1, 1'b0, 8'h00);
        cyc(2'b00, 16'hB2A1, 1'b1, 8'h99);
        chk("post_rst_ack", {22'd0, ack, res_o}, {22'd0, 2'b01, 8'h99});
        cyc(2'b00, 16'hB2A1, 1'b0, 8'h00);

        // ---- stalled RUN (dp_done held low) ----
        cyc(2'b10, 16'hB2A1, 1'b0, 8'h00);
        chk("stall_gnt", {30'd0, gnt}, 32'd2);
        cyc(2'b10, 16'hB2A1, 1'b0, 8'h00);
        got_ack  = 1'b0;
        err_seen = 1'b0;
        busy_low = 1'b0;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            if (!got_ack) begin
                cyc(2'b10, 16'hB2A1, 1'b0, 8'h00);
                if (err) err_seen = 1'b1;
                if (!busy) busy_low = 1'b1;
                if (ack != 2'b00) begin
                    got_ack = 1'b1;
                    n = k;
                end
            end
        end
`ifdef BO_ARB_TIMEOUT_EN
        chk("timeout_ack_seen", {31'd0, got_ack}, 32'd1);
        chk("timeout_latency", n, TIMEOUT);
        chk("timeout_ack_err", {21'd0, ack, err, res_o}, {21'd0, 2'b10, 1'b1, 8'h00});
        cyc(2'b11, 16'hB2A1, 1'b0, 8'h00);
        chk("timeout_clr", {28'd0, dp_clr, busy, gnt}, 32'hC);
        chk("timeout_err_drop", {31'd0, err}, 32'd0);
        cyc(2'b11, 16'hB2A1, 1'b0, 8'h00);
        chk("timeout_idle", {30'd0, dp_clr, busy}, 32'd0);
        cyc(2'b11, 16'hB2A1, 1'b0, 8'h00);
        chk("timeout_next_gnt", {22'd0, gnt, dp_x}, {22'd0, 2'b01, 8'hA1});
        cyc(2'b11, 16'hB2A1, 1'b0, 8'h00);
        cyc(2'b00, 16'hB2A1, 1'b1, 8'h5A);
        chk("timeout_next_ack", {21'd0, ack, err, res_o}, {21'd0, 2'b01, 1'b0, 8'h5A});
`else
        chk("stall_no_ack", {31'd0, got_ack}, 32'd0);
        chk("stall_no_err", {31'd0, err_seen}, 32'd0);
        chk("stall_busy", {31'd0, busy_low}, 32'd0);
        cyc(2'b10, 16'hB2A1, 1'b1, 8'h5A);
        chk("stall_late_ack", {21'd0, ack, err, res_o}, {21'd0, 2'b10, 1'b0, 8'h5A});
`endif
        cyc(2'b00, 16'hB2A1, 1'b0, 8'h00);
        chk("final_idle", {28'd0, gnt, ack}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
